// File: rtl/spi_xfer_sequencer.sv
// SPI transaction sequencer: CS assert -> setup -> shift -> hold -> CS deassert,
// with SCLK generation, sample/shift strobes and chipselect_select pulses.
module spi_xfer_sequencer #(
  parameter int NUM_CS = 4,
  parameter int CNT_W  = 8,
  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cs_auto,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic [4:0]        word_size,
  input  logic              cpol,
  input  logic              burst,
  input  logic [CNT_W-1:0]  baud_div,
  input  logic [CNT_W-1:0]  setup_cycles,
  input  logic [CNT_W-1:0]  hold_cycles,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              cs_pull_low,
  output logic              cs_pull_high,
  output logic [NUM_CS-1:0] select,
  output logic              sclk,
  output logic              sample_en,
  output logic              shift_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ASSERT, S_SETUP, S_TXRX, S_HOLD, S_DEASSERT
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt, wait_nxt;
  logic [CNT_W-1:0]   half_cnt, half_nxt;
  logic [5:0]         bits_left, bits_nxt;
  logic               phase, phase_nxt;
  logic               sclk_nxt, sample_nxt, shift_nxt;
  logic [NUM_CS-1:0]  select_nxt, sel_onehot;
  logic               half_exp, last_edge, hold_end, accept;

  assign sel_onehot = NUM_CS'(1) << cs_sel;
  assign half_exp   = (half_cnt == '0);
  assign last_edge  = (state == S_TXRX) && half_exp && phase && (bits_left == 6'd1);
  // A zero hold time makes the final trailing edge itself the end of hold.
  assign hold_end   = ((state == S_HOLD) && (wait_cnt == '0)) ||
                      (last_edge && (hold_cycles == '0));

  // tx_valid/tx_ready: a word is taken on a rising clk edge where both are high;
  // tx_ready is combinational and only high in IDLE or at the end of a burst hold.
  assign tx_ready = enable && !reset && ((state == S_IDLE) || (hold_end && burst));
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      half_cnt     <= '0;
      bits_left    <= '0;
      phase        <= 1'b0;
      sclk         <= cpol;
      sample_en    <= 1'b0;
      shift_en     <= 1'b0;
      select       <= '0;
      cs_pull_low  <= 1'b0;
      cs_pull_high <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_nxt;
      half_cnt     <= half_nxt;
      bits_left    <= bits_nxt;
      phase        <= phase_nxt;
      sclk         <= sclk_nxt;
      sample_en    <= sample_nxt;
      shift_en     <= shift_nxt;
      select       <= select_nxt;
      cs_pull_low  <= (state_nxt == S_ASSERT) && cs_auto;
      cs_pull_high <= (state_nxt == S_DEASSERT) && cs_auto;
      busy         <= (state_nxt != S_IDLE);
      done         <= (state == S_DEASSERT) && enable;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept) state_nxt = S_ASSERT;
      S_ASSERT:   state_nxt = (setup_cycles == '0) ? S_TXRX : S_SETUP;
      S_SETUP:    if (wait_cnt == '0) state_nxt = S_TXRX;
      S_TXRX:     if (last_edge) state_nxt = hold_end ? (accept ? S_TXRX : S_DEASSERT) : S_HOLD;
      S_HOLD:     if (wait_cnt == '0) state_nxt = accept ? S_TXRX : S_DEASSERT;
      S_DEASSERT: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (!enable) state_nxt = S_IDLE;
  end

  always_comb begin
    wait_nxt   = wait_cnt;
    half_nxt   = half_cnt;
    bits_nxt   = bits_left;
    phase_nxt  = phase;
    sclk_nxt   = sclk;
    sample_nxt = 1'b0;
    shift_nxt  = 1'b0;
    select_nxt = select;
    case (state)
      S_ASSERT: begin
        half_nxt = baud_div;
        wait_nxt = (setup_cycles != '0) ? setup_cycles - CNT_W'(1) : '0;
      end
      S_SETUP: begin
        half_nxt = baud_div;
        if (wait_cnt != '0) wait_nxt = wait_cnt - CNT_W'(1);
      end
      S_TXRX: begin
        if (half_exp) begin
          half_nxt = baud_div;
          sclk_nxt = ~sclk;
          if (!phase) begin
            sample_nxt = 1'b1;
            phase_nxt  = 1'b1;
          end else begin
            shift_nxt  = 1'b1;
            phase_nxt  = 1'b0;
            bits_nxt   = bits_left - 6'd1;
          end
        end else begin
          half_nxt = half_cnt - CNT_W'(1);
        end
        if (last_edge) begin
          sclk_nxt = cpol;
          wait_nxt = (hold_cycles != '0) ? hold_cycles - CNT_W'(1) : '0;
        end
      end
      S_HOLD: if (wait_cnt != '0) wait_nxt = wait_cnt - CNT_W'(1);
      default: ;
    endcase
    // A new word (first or burst continuation) restarts the bit sequence.
    if (accept) begin
      bits_nxt  = {1'b0, word_size} + 6'd1;
      phase_nxt = 1'b0;
      half_nxt  = baud_div;
    end
    if (state == S_IDLE) select_nxt = sel_onehot;
    if (state_nxt == S_IDLE) begin
      wait_nxt   = '0;
      half_nxt   = '0;
      bits_nxt   = '0;
      phase_nxt  = 1'b0;
      sclk_nxt   = cpol;
      sample_nxt = 1'b0;
      shift_nxt  = 1'b0;
      select_nxt = enable ? sel_onehot : '0;
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer: directed scenarios plus random transfers, each
// checked at transaction end against an arithmetic model of the expected trace.
module tb_spi_xfer_sequencer;
  logic       clk = 1'b0;
  logic       reset, enable, cs_auto, cpol, burst, tx_valid;
  logic [1:0] cs_sel;
  logic [4:0] word_size;
  logic [7:0] baud_div, setup_cycles, hold_cycles;
  logic       tx_ready, cs_pull_low, cs_pull_high, sclk, sample_en, shift_en, busy, done;
  logic [3:0] select;

  always #5 clk = ~clk;

  spi_xfer_sequencer #(.NUM_CS(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cs_auto(cs_auto), .cs_sel(cs_sel),
    .word_size(word_size), .cpol(cpol), .burst(burst), .baud_div(baud_div),
    .setup_cycles(setup_cycles), .hold_cycles(hold_cycles), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .cs_pull_low(cs_pull_low), .cs_pull_high(cs_pull_high),
    .select(select), .sclk(sclk), .sample_en(sample_en), .shift_en(shift_en),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic        aborted;
    logic        cnt_chk;
    logic [3:0]  sel;
    logic [1:0]  pl;
    logic [1:0]  ph;
    logic [7:0]  hs;
    logic [15:0] bits;
    logic [15:0] dur;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   wsz[4];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected trace of a complete transfer of nw words from the current settings.
  function automatic exp_t model(input int nw);
    exp_t e;
    int   b = 0;
    for (int k = 0; k < nw; k++) b += wsz[k] + 1;
    e.aborted = 1'b0;
    e.cnt_chk = 1'b1;
    e.sel     = 4'b0001 << cs_sel;
    e.pl      = {1'b0, cs_auto};
    e.ph      = {1'b0, cs_auto};
    e.hs      = 8'(nw);
    e.bits    = 16'(b);
    e.dur     = 16'(3 + int'(setup_cycles) + nw * int'(hold_cycles) + 2 * b * (int'(baud_div) + 1));
    return e;
  endfunction

  // Monitor: tracks one transaction from its IDLE handshake to the fall of busy.
  int   cyc = 0, start = 0, samples, shifts, toggles, lo, hi, hs, lo_at, hi_at, sel_bad;
  logic tracking = 1'b0, prev_busy = 1'b0, prev_sclk;
  exp_t cur, e;

  always @(negedge clk) begin
    cyc++;
    if (!tracking && tx_valid && tx_ready && !busy) begin
      check("start_has_expect", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) cur = exp_q[0];
      tracking = 1'b1; start = cyc; samples = 0; shifts = 0; toggles = 0;
      lo = 0; hi = 0; hs = 0; lo_at = -1; hi_at = -1; sel_bad = 0; prev_sclk = sclk;
    end
    if (tracking) begin
      if (tx_valid && tx_ready) hs++;
      if (sample_en) samples++;
      if (shift_en) shifts++;
      if (sclk !== prev_sclk) toggles++;
      prev_sclk = sclk;
      if (cs_pull_low) begin lo++; lo_at = cyc - start; end
      if (cs_pull_high) begin hi++; hi_at = cyc - start; end
      if (busy && select !== cur.sel) sel_bad++;
      if (prev_busy && !busy) begin
        tracking = 1'b0;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = cur;
        check("done", int'(done), int'(!e.aborted));
        check("pull_low_cnt", lo, int'(e.pl));
        check("pull_high_cnt", hi, int'(e.ph));
        check("handshakes", hs, int'(e.hs));
        check("select_held", sel_bad, 0);
        check("sclk_idle", int'(sclk), int'(cpol));
        check("pull_low_at", lo_at, (e.pl != 0) ? 1 : -1);
        if (e.cnt_chk) begin
          check("sample_cnt", samples, int'(e.bits));
          check("shift_cnt", shifts, int'(e.bits));
        end
        if (!e.aborted) begin
          check("sclk_toggles", toggles, 2 * int'(e.bits));
          check("duration", cyc - start, int'(e.dur));
          check("pull_high_at", hi_at, (e.ph != 0) ? int'(e.dur) - 1 : -1);
        end
      end
    end
    prev_busy = busy;
  end

  task automatic hs_wait();
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 1500) begin @(negedge clk); n++; end
    check("hs_timeout", int'(tx_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 1500) begin @(negedge clk); n++; end
    check("idle_timeout", int'(busy), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic send(input int nw);
    exp_q.push_back(model(nw));
    tx_valid = 1'b1;
    for (int k = 0; k < nw; k++) begin
      word_size = 5'(wsz[k]);
      hs_wait();
    end
    tx_valid = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    int   cnt, n, nw;
    exp_t ab;
    reset = 1'b1; enable = 1'b1; cs_auto = 1'b1; cpol = 1'b1; burst = 1'b0;
    tx_valid = 1'b1; cs_sel = 2'd2; word_size = 5'd7;
    baud_div = 8'd1; setup_cycles = 8'd2; hold_cycles = 8'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_ready", int'(tx_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sclk", int'(sclk), 1);
    check("rst_select", int'(select), 0);
    check("rst_done", int'(done), 0);
    check("rst_strobes", int'({sample_en, shift_en, cs_pull_low, cs_pull_high}), 0);
    @(posedge clk); #1;
    reset = 1'b0; tx_valid = 1'b0; cpol = 1'b0;
    settle(); settle();

    // Reference transfer: 8 bits, baud_div 1, setup/hold 2, slave 2.
    wsz[0] = 7;
    send(1);
    @(negedge clk);
    check("sel_literal", int'(select), 4'b0100);
    wait_idle();

    // Burst of two words with CS held low.
    burst = 1'b1; wsz[0] = 7; wsz[1] = 3;
    settle();
    send(2);
    wait_idle();

    // Manual chipselect: identical timing, no CS pulses.
    burst = 1'b0; cs_auto = 1'b0; wsz[0] = 7;
    settle();
    send(1);
    wait_idle();

    // Enable dropped at the 3rd shift strobe.
    cs_auto = 1'b1; wsz[0] = 7;
    settle();
    ab = model(1);
    ab.aborted = 1'b1; ab.ph = 2'd0; ab.bits = 16'd3;
    exp_q.push_back(ab);
    tx_valid = 1'b1; word_size = 5'd7;
    hs_wait();
    tx_valid = 1'b0;
    cnt = 0; n = 0;
    while (cnt < 3 && n < 1000) begin @(negedge clk); n++; if (shift_en) cnt++; end
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_sclk", int'(sclk), int'(cpol));
    check("abort_done", int'(done), 0);
    check("abort_pull_high", int'(cs_pull_high), 0);
    @(posedge clk); #1;
    enable = 1'b1;
    settle();
    send(1);
    wait_idle();

    // Fastest corner: baud_div 0, no setup/hold, one bit, sclk idle high.
    cpol = 1'b1; baud_div = 8'd0; setup_cycles = 8'd0; hold_cycles = 8'd0; wsz[0] = 0;
    settle(); settle();
    @(negedge clk);
    check("cpol1_idle", int'(sclk), 1);
    @(posedge clk); #1;
    send(1);
    wait_idle();

    // Reset during shifting with tx_valid high.
    cpol = 1'b0; baud_div = 8'd1; setup_cycles = 8'd1; hold_cycles = 8'd1; wsz[0] = 7;
    settle();
    ab = model(1);
    ab.aborted = 1'b1; ab.cnt_chk = 1'b0; ab.ph = 2'd0;
    exp_q.push_back(ab);
    tx_valid = 1'b1; word_size = 5'd7;
    hs_wait();
    tx_valid = 1'b0;
    n = 0;
    while (!sample_en && n < 1000) begin @(negedge clk); n++; end
    reset = 1'b1; tx_valid = 1'b1;
    @(negedge clk);
    check("rst2_busy", int'(busy), 0);
    check("rst2_tx_ready", int'(tx_ready), 0);
    check("rst2_outputs", int'({sample_en, shift_en, cs_pull_low, cs_pull_high, done}), 0);
    check("rst2_select", int'(select), 0);
    check("rst2_sclk", int'(sclk), 0);
    @(posedge clk); #1;
    reset = 1'b0; tx_valid = 1'b0;
    settle();

    // Random transfers and bursts.
    for (int t = 0; t < 30 && n_bad < 10; t++) begin
      cs_auto      = 1'($urandom_range(0, 1));
      cpol         = 1'($urandom_range(0, 1));
      cs_sel       = 2'($urandom_range(0, 3));
      baud_div     = 8'($urandom_range(0, 2));
      setup_cycles = 8'($urandom_range(0, 3));
      hold_cycles  = 8'($urandom_range(0, 3));
      burst        = 1'($urandom_range(0, 1));
      nw           = burst ? $urandom_range(1, 3) : 1;
      for (int k = 0; k < nw; k++) wsz[k] = $urandom_range(0, 31);
      settle(); settle();
      send(nw);
      wait_idle();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
